// File: rtl/sdcard_cmd_pkg.sv
// Shared definitions for the SD command scheduler: command indices, response
// status codes and scheduler states.
package sdcard_cmd_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD12 = 6'd12;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD23 = 6'd23;
    localparam logic [5:0] CMD24 = 6'd24;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    // APP_CMD flag in the R1 card status returned for CMD55
    localparam int unsigned APP_CMD_BIT = 5;

    typedef enum logic [1:0] {
        ST_OK         = 2'b00,
        ST_TIMEOUT    = 2'b01,
        ST_CRC        = 2'b10,
        ST_APP_REJECT = 2'b11
    } cmd_status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_APP,
        S_WAIT_APP,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_t;

endpackage

// File: rtl/sdcard_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or above ptr, with wrap-around.
// Purely combinational; the caller owns and advances the pointer.
module sdcard_rr_arbiter #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx,
    output logic               any_valid
);

    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && valid[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/sdcard_cmd_scheduler.sv
// Shares one SD command engine between NUM_REQ requesters: round-robin grant,
// automatic CMD55 prefix for application commands, retry and watchdog.
module sdcard_cmd_scheduler
    import sdcard_cmd_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic                  PCLK_i,
    input  logic                  PRESETn_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [NUM_REQ*6-1:0]  req_index_i,
    input  logic [NUM_REQ*32-1:0] req_arg_i,
    input  logic [NUM_REQ-1:0]    req_acmd_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [1:0]            rsp_status_o,
    output logic [39:0]           rsp_data_o,
    input  logic [15:0]           rca_i,
    output logic                  sched_idle_o,
    output logic [5:0]            eng_cmd_index_o,
    output logic [31:0]           eng_cmd_argument_o,
    output logic                  eng_cmd_start_o,
    input  logic                  eng_cmd_busy_i,
    input  logic                  eng_cmd_done_i,
    input  logic                  eng_cmd_timeout_i,
    input  logic                  eng_cmd_crc_error_i,
    input  logic [39:0]           eng_cmd_response_i
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);

    sched_state_t       state_q, state_n;
    logic [PW-1:0]      ptr_q, ptr_n;
    logic [2:0]         retry_q, retry_n;
    logic [WW-1:0]      wdog_q, wdog_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [5:0]         index_q, index_n;
    logic [31:0]        arg_q, arg_n;
    logic               acmd_q, acmd_n;

    logic [NUM_REQ-1:0] ready_n, rspv_n;
    logic [1:0]         status_n;
    logic [39:0]        data_n;
    logic [5:0]         eidx_n;
    logic [31:0]        earg_n;
    logic               start_n, idle_n;
    logic               fail;
    cmd_status_t        fail_status;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PW-1:0]      arb_idx;
    logic               arb_any;

    sdcard_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid     (req_valid_i),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    always_comb begin
        state_n     = state_q;
        ptr_n       = ptr_q;
        retry_n     = retry_q;
        wdog_n      = wdog_q;
        grant_n     = grant_q;
        index_n     = index_q;
        arg_n       = arg_q;
        acmd_n      = acmd_q;
        ready_n     = '0;
        rspv_n      = '0;
        status_n    = rsp_status_o;
        data_n      = rsp_data_o;
        eidx_n      = eng_cmd_index_o;
        earg_n      = eng_cmd_argument_o;
        start_n     = 1'b0;
        fail        = 1'b0;
        fail_status = ST_TIMEOUT;

        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    ready_n = arb_grant;
                    grant_n = arb_grant;
                    for (int unsigned r = 0; r < NUM_REQ; r++) begin
                        if (arb_grant[r]) begin
                            index_n = req_index_i[6*r +: 6];
                            arg_n   = req_arg_i[32*r +: 32];
                            acmd_n  = req_acmd_i[r];
                        end
                    end
                    ptr_n   = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                    state_n = (req_acmd_i & arb_grant) != '0 ? S_ISSUE_APP : S_ISSUE;
                end
            end
            S_ISSUE_APP: begin
                if (!eng_cmd_busy_i) begin
                    start_n = 1'b1;
                    eidx_n  = CMD55;
                    earg_n  = {rca_i, 16'h0000};
                    wdog_n  = '0;
                    state_n = S_WAIT_APP;
                end
            end
            S_ISSUE: begin
                if (!eng_cmd_busy_i) begin
                    start_n = 1'b1;
                    eidx_n  = index_q;
                    earg_n  = arg_q;
                    wdog_n  = '0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT_APP, S_WAIT: begin
                wdog_n = wdog_q + 1'b1;
                fail   = 1'b1;
                if (eng_cmd_timeout_i) begin
                    fail_status = ST_TIMEOUT;
                end else if (eng_cmd_crc_error_i) begin
                    fail_status = ST_CRC;
                end else if (eng_cmd_done_i) begin
                    fail = 1'b0;
                    if (state_q == S_WAIT_APP && eng_cmd_response_i[APP_CMD_BIT]) begin
                        state_n = S_ISSUE;
                    end else begin
                        rspv_n   = grant_q;
                        status_n = (state_q == S_WAIT) ? ST_OK : ST_APP_REJECT;
                        data_n   = eng_cmd_response_i;
                        state_n  = S_RESP;
                    end
                end else if (wdog_n != WW'(WDOG_CYCLES)) begin
                    fail = 1'b0;
                end
                // A failed attempt of an ACMD restarts from the CMD55 prefix
                if (fail) begin
                    if (retry_q < 3'(MAX_RETRY)) begin
                        retry_n = retry_q + 1'b1;
                        state_n = acmd_q ? S_ISSUE_APP : S_ISSUE;
                    end else begin
                        rspv_n   = grant_q;
                        status_n = fail_status;
                        state_n  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                retry_n = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        idle_n = (state_n == S_IDLE);
    end

    always_ff @(posedge PCLK_i) begin
        if (!PRESETn_i) begin
            state_q            <= S_IDLE;
            ptr_q              <= '0;
            retry_q            <= '0;
            wdog_q             <= '0;
            grant_q            <= '0;
            index_q            <= '0;
            arg_q              <= '0;
            acmd_q             <= 1'b0;
            req_ready_o        <= '0;
            rsp_valid_o        <= '0;
            rsp_status_o       <= '0;
            rsp_data_o         <= '0;
            eng_cmd_index_o    <= '0;
            eng_cmd_argument_o <= '0;
            eng_cmd_start_o    <= 1'b0;
            sched_idle_o       <= 1'b1;
        end else begin
            state_q            <= state_n;
            ptr_q              <= ptr_n;
            retry_q            <= retry_n;
            wdog_q             <= wdog_n;
            grant_q            <= grant_n;
            index_q            <= index_n;
            arg_q              <= arg_n;
            acmd_q             <= acmd_n;
            req_ready_o        <= ready_n;
            rsp_valid_o        <= rspv_n;
            rsp_status_o       <= status_n;
            rsp_data_o         <= data_n;
            eng_cmd_index_o    <= eidx_n;
            eng_cmd_argument_o <= earg_n;
            eng_cmd_start_o    <= start_n;
            sched_idle_o       <= idle_n;
        end
    end

    // Ready is registered, so a requester may drop valid in the cycle ready is seen
    req_hold_a: assert property (@(posedge PCLK_i) disable iff (!PRESETn_i)
        ~|($past(req_valid_i) & ~req_valid_i & ~$past(req_ready_o) & ~req_ready_o));

endmodule

// File: tb/tb_sdcard_cmd_scheduler.sv
// Self-checking bench for sdcard_cmd_scheduler with a behavioural engine model.
module tb_sdcard_cmd_scheduler;

    localparam int NR = 3;
    localparam int MR = 2;
    localparam int WD = 64;

    logic            PCLK_i = 1'b0;
    logic            PRESETn_i = 1'b0;
    logic [NR-1:0]   req_valid_i = '0;
    logic [NR*6-1:0] req_index_i = '0;
    logic [NR*32-1:0] req_arg_i = '0;
    logic [NR-1:0]   req_acmd_i = '0;
    logic [NR-1:0]   req_ready_o, rsp_valid_o;
    logic [1:0]      rsp_status_o;
    logic [39:0]     rsp_data_o;
    logic [15:0]     rca_i = '0;
    logic            sched_idle_o;
    logic [5:0]      eng_cmd_index_o;
    logic [31:0]     eng_cmd_argument_o;
    logic            eng_cmd_start_o;
    logic            eng_cmd_busy_i = 1'b0, eng_cmd_done_i = 1'b0;
    logic            eng_cmd_timeout_i = 1'b0, eng_cmd_crc_error_i = 1'b0;
    logic [39:0]     eng_cmd_response_i = '0;

    sdcard_cmd_scheduler #(.NUM_REQ(NR), .MAX_RETRY(MR), .WDOG_CYCLES(WD)) dut (
        .PCLK_i(PCLK_i), .PRESETn_i(PRESETn_i),
        .req_valid_i(req_valid_i), .req_index_i(req_index_i), .req_arg_i(req_arg_i),
        .req_acmd_i(req_acmd_i), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o), .rca_i(rca_i),
        .sched_idle_o(sched_idle_o), .eng_cmd_index_o(eng_cmd_index_o),
        .eng_cmd_argument_o(eng_cmd_argument_o), .eng_cmd_start_o(eng_cmd_start_o),
        .eng_cmd_busy_i(eng_cmd_busy_i), .eng_cmd_done_i(eng_cmd_done_i),
        .eng_cmd_timeout_i(eng_cmd_timeout_i), .eng_cmd_crc_error_i(eng_cmd_crc_error_i),
        .eng_cmd_response_i(eng_cmd_response_i)
    );

    always #5 PCLK_i = ~PCLK_i;

    int cyc = 0;
    always @(posedge PCLK_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // Engine behaviour: mode 0 done, 1 timeout, 2 crc error, 3 never answers
    int          eng_app_mode = 0, eng_cmd_mode = 0, eng_delay = 4, eng_tail = 0;
    logic [39:0] eng_app_resp = 40'h20, eng_resp = '0;
    logic [37:0] st_q[$];
    int          start_cyc[$];
    int          done_cyc = 0;
    int          busy_viol = 0;

    initial begin
        int e_cnt, b_cnt, e_mode;
        logic [39:0] e_resp;
        logic busy_at_edge;
        e_cnt = 0; b_cnt = 0; e_mode = 0; e_resp = '0;
        forever begin
            @(negedge PCLK_i);
            busy_at_edge = eng_cmd_busy_i;
            eng_cmd_done_i = 1'b0; eng_cmd_timeout_i = 1'b0; eng_cmd_crc_error_i = 1'b0;
            if (b_cnt > 0) begin
                b_cnt--;
                if (b_cnt == 0) eng_cmd_busy_i = 1'b0;
            end
            if (e_cnt > 0) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    eng_cmd_response_i = e_resp;
                    done_cyc = cyc;
                    case (e_mode)
                        0: eng_cmd_done_i = 1'b1;
                        1: eng_cmd_timeout_i = 1'b1;
                        default: eng_cmd_crc_error_i = 1'b1;
                    endcase
                    if (eng_tail == 0) eng_cmd_busy_i = 1'b0;
                    else b_cnt = eng_tail;
                end
            end
            if (eng_cmd_start_o) begin
                if (busy_at_edge) busy_viol++;
                st_q.push_back({eng_cmd_index_o, eng_cmd_argument_o});
                start_cyc.push_back(cyc);
                e_mode = (eng_cmd_index_o == 6'd55) ? eng_app_mode : eng_cmd_mode;
                e_resp = (eng_cmd_index_o == 6'd55) ? eng_app_resp : eng_resp;
                if (e_mode != 3) begin
                    e_cnt = eng_delay;
                    eng_cmd_busy_i = 1'b1;
                end
            end
        end
    end

    // Reference: attempts of (optional CMD55, command), outcome per attempt from engine modes
    logic [37:0] exp_st[$];
    logic [1:0]  exp_status;
    logic [39:0] exp_data;

    task automatic model_txn(input logic acmd, input logic [5:0] idx, input logic [31:0] arg);
        exp_st.delete();
        exp_status = 2'b01;
        exp_data = '0;
        for (int a = 0; a <= MR; a++) begin
            if (acmd) begin
                exp_st.push_back({6'd55, rca_i, 16'h0000});
                if (eng_app_mode != 0) begin
                    exp_status = (eng_app_mode == 2) ? 2'b10 : 2'b01;
                    continue;
                end
                if (!eng_app_resp[5]) begin
                    exp_status = 2'b11;
                    exp_data = eng_app_resp;
                    return;
                end
            end
            exp_st.push_back({idx, arg});
            if (eng_cmd_mode == 0) begin
                exp_status = 2'b00;
                exp_data = eng_resp;
                return;
            end
            exp_status = (eng_cmd_mode == 2) ? 2'b10 : 2'b01;
        end
    endtask

    logic          got_rsp;
    logic [NR-1:0] rdy_vec, rsp_vec;
    logic [1:0]    rsp_stat;
    logic [39:0]   rsp_dat;
    int            rdy_cyc, rsp_cyc, rdy_cnt;

    task automatic run_txn(input int r, input logic acmd, input logic [5:0] idx,
                           input logic [31:0] arg, input int budget);
        st_q.delete(); start_cyc.delete();
        got_rsp = 1'b0; rdy_vec = '0; rsp_vec = '0; rdy_cnt = 0; rdy_cyc = 0; rsp_cyc = 0;
        req_index_i[6*r +: 6] = idx;
        req_arg_i[32*r +: 32] = arg;
        req_acmd_i[r] = acmd;
        req_valid_i[r] = 1'b1;
        for (int c = 0; c < budget && !got_rsp; c++) begin
            @(negedge PCLK_i);
            if (req_ready_o != '0) begin
                rdy_vec = req_ready_o; rdy_cyc = cyc; rdy_cnt++;
                req_valid_i[r] = 1'b0;
            end
            if (rsp_valid_o != '0) begin
                got_rsp = 1'b1; rsp_vec = rsp_valid_o; rsp_stat = rsp_status_o;
                rsp_dat = rsp_data_o; rsp_cyc = cyc;
            end
        end
        req_valid_i[r] = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge PCLK_i);
        PRESETn_i = 1'b0; req_valid_i = '0;
        repeat (2) @(negedge PCLK_i);
        PRESETn_i = 1'b1;
    endtask

    task automatic test_reset();
        logic [128:0] got;
        apply_reset();
        PRESETn_i = 1'b0;
        @(negedge PCLK_i);
        got = {req_ready_o, rsp_valid_o, rsp_status_o, rsp_data_o, eng_cmd_index_o,
               eng_cmd_argument_o, eng_cmd_start_o, sched_idle_o};
        n_checks++;
        if (got !== 129'd1) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, 129'd1);
        end
        PRESETn_i = 1'b1;
        @(negedge PCLK_i);
    endtask

    task automatic test_single();
        logic [37:0] g;
        eng_cmd_mode = 0; eng_delay = 20; eng_tail = 0; eng_resp = 40'h0000000900;
        model_txn(1'b0, 6'd17, 32'h200);
        run_txn(0, 1'b0, 6'd17, 32'h200, 500);
        n_checks++;
        if (got_rsp !== 1'b1) begin n_fail++; $display("FAIL single_rsp: got %b expected 1", got_rsp); end
        n_checks++;
        if (rdy_vec !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b expected 001", rdy_vec); end
        n_checks++;
        if (st_q.size() !== 1) begin n_fail++; $display("FAIL single_starts: got %0d expected 1", st_q.size()); end
        g = (st_q.size() > 0) ? st_q[0] : 'x;
        n_checks++;
        if (g !== {6'd17, 32'h200}) begin n_fail++; $display("FAIL single_cmd: got %h expected %h", g, {6'd17, 32'h200}); end
        n_checks++;
        if ({rsp_vec, rsp_stat, rsp_dat} !== {3'b001, 2'b00, 40'h0000000900}) begin
            n_fail++; $display("FAIL single_resp: got %b/%b/%h expected 001/00/0000000900", rsp_vec, rsp_stat, rsp_dat);
        end
        n_checks++;
        if (((start_cyc.size() > 0) ? start_cyc[0] : -1) !== rdy_cyc + 1) begin
            n_fail++; $display("FAIL single_start_latency: got %0d expected %0d", (start_cyc.size() > 0) ? start_cyc[0] : -1, rdy_cyc + 1);
        end
        n_checks++;
        if (rsp_cyc !== done_cyc + 1) begin
            n_fail++; $display("FAIL single_rsp_latency: got %0d expected %0d", rsp_cyc, done_cyc + 1);
        end
    endtask

    task automatic test_round_robin();
        int gq[$];
        logic [NR-1:0] rq[$];
        int exp_g[4] = '{0, 1, 2, 0};
        logic [NR-1:0] exp_r[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic again0;
        apply_reset();
        eng_cmd_mode = 0; eng_delay = 3; eng_tail = 0; eng_resp = 40'h12_3456_789A;
        again0 = 1'b1;
        for (int r = 0; r < NR; r++) begin
            req_index_i[6*r +: 6] = 6'(8 + r);
            req_arg_i[32*r +: 32] = $urandom;
            req_acmd_i[r] = 1'b0;
        end
        req_valid_i = '1;
        for (int c = 0; c < 400 && (rq.size() < 4 || c < 300); c++) begin
            @(negedge PCLK_i);
            if (req_ready_o != '0) begin
                n_checks++;
                if ($countones(req_ready_o) !== 1) begin
                    n_fail++; $display("FAIL rr_onehot: got %b expected one-hot", req_ready_o);
                end
                for (int r = 0; r < NR; r++) begin
                    if (req_ready_o[r]) begin
                        gq.push_back(r);
                        if (r == 0 && again0) again0 = 1'b0;
                        else req_valid_i[r] = 1'b0;
                    end
                end
            end
            if (rsp_valid_o != '0) rq.push_back(rsp_valid_o);
            if (rq.size() >= 4 && c > 100) break;
        end
        n_checks++;
        if (gq.size() !== 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 4", gq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (((i < gq.size()) ? gq[i] : -1) !== exp_g[i]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, (i < gq.size()) ? gq[i] : -1, exp_g[i]);
            end
            n_checks++;
            if (((i < rq.size()) ? rq[i] : 'x) !== exp_r[i]) begin
                n_fail++; $display("FAIL rr_rsp[%0d]: got %b expected %b", i, (i < rq.size()) ? rq[i] : 'x, exp_r[i]);
            end
        end
        n_checks++;
        if (sched_idle_o !== 1'b1) begin n_fail++; $display("FAIL rr_idle: got %b expected 1", sched_idle_o); end
    endtask

    task automatic test_acmd();
        logic [37:0] g;
        rca_i = 16'h1234; eng_app_mode = 0; eng_cmd_mode = 0; eng_delay = 5; eng_tail = 1;
        for (int b = 1; b >= 0; b--) begin
            eng_app_resp = {8'h37, $urandom};
            eng_app_resp[5] = 1'(b);
            eng_resp = {8'hC0, $urandom};
            model_txn(1'b1, 6'd41, 32'h40FF8000);
            run_txn(1, 1'b1, 6'd41, 32'h40FF8000, 500);
            n_checks++;
            if (st_q.size() !== exp_st.size()) begin
                n_fail++; $display("FAIL acmd%0d_starts: got %0d expected %0d", b, st_q.size(), exp_st.size());
            end
            for (int i = 0; i < exp_st.size(); i++) begin
                g = (i < st_q.size()) ? st_q[i] : 'x;
                n_checks++;
                if (g !== exp_st[i]) begin n_fail++; $display("FAIL acmd%0d_cmd[%0d]: got %h expected %h", b, i, g, exp_st[i]); end
            end
            n_checks++;
            if ({got_rsp, rsp_vec, rsp_stat, rsp_dat} !== {1'b1, 3'b010, exp_status, exp_data}) begin
                n_fail++; $display("FAIL acmd%0d_resp: got %b/%b/%b/%h expected 1/010/%b/%h", b, got_rsp, rsp_vec, rsp_stat, rsp_dat, exp_status, exp_data);
            end
        end
        eng_tail = 0;
    endtask

    task automatic test_retry();
        logic [31:0] a;
        eng_delay = 4;
        for (int m = 2; m >= 1; m--) begin
            eng_cmd_mode = m;
            a = $urandom;
            model_txn(1'b0, 6'd24, a);
            run_txn(2, 1'b0, 6'd24, a, 500);
            n_checks++;
            if (st_q.size() !== MR + 1) begin n_fail++; $display("FAIL retry%0d_starts: got %0d expected %0d", m, st_q.size(), MR + 1); end
            n_checks++;
            if ({got_rsp, rsp_vec, rsp_stat} !== {1'b1, 3'b100, 2'(m)}) begin
                n_fail++; $display("FAIL retry%0d_resp: got %b/%b/%b expected 1/100/%b", m, got_rsp, rsp_vec, rsp_stat, 2'(m));
            end
        end
        eng_cmd_mode = 0;
    endtask

    task automatic test_watchdog();
        int lat;
        eng_cmd_mode = 3;
        run_txn(0, 1'b0, 6'd12, 32'h0, 1000);
        lat = rsp_cyc - ((start_cyc.size() > 0) ? start_cyc[0] : rsp_cyc);
        n_checks++;
        if ({got_rsp, rsp_stat} !== {1'b1, 2'b01}) begin
            n_fail++; $display("FAIL wdog_resp: got %b/%b expected 1/01", got_rsp, rsp_stat);
        end
        n_checks++;
        if (st_q.size() !== MR + 1) begin n_fail++; $display("FAIL wdog_starts: got %0d expected %0d", st_q.size(), MR + 1); end
        n_checks++;
        if (!(lat >= 3 * WD && lat <= 3 * WD + 8)) begin
            n_fail++; $display("FAIL wdog_latency: got %0d expected %0d..%0d", lat, 3 * WD, 3 * WD + 8);
        end
        eng_cmd_mode = 0;
    endtask

    task automatic test_reset_mid();
        logic [128:0] got;
        int extra;
        eng_cmd_mode = 0; eng_delay = 30; eng_resp = 40'hAB_CDEF_0123;
        st_q.delete();
        req_index_i[5:0] = 6'd18; req_arg_i[31:0] = 32'h1000; req_acmd_i[0] = 1'b0; req_valid_i[0] = 1'b1;
        for (int c = 0; c < 50 && st_q.size() == 0; c++) begin
            @(negedge PCLK_i);
            if (req_ready_o[0]) req_valid_i[0] = 1'b0;
        end
        req_valid_i = '0;
        n_checks++;
        if (st_q.size() !== 1) begin n_fail++; $display("FAIL midrst_start: got %0d expected 1", st_q.size()); end
        repeat (5) @(negedge PCLK_i);
        PRESETn_i = 1'b0;
        @(negedge PCLK_i);
        got = {req_ready_o, rsp_valid_o, rsp_status_o, rsp_data_o, eng_cmd_index_o,
               eng_cmd_argument_o, eng_cmd_start_o, sched_idle_o};
        n_checks++;
        if (got !== 129'd1) begin n_fail++; $display("FAIL midrst_outputs: got %h expected %h", got, 129'd1); end
        @(negedge PCLK_i);
        PRESETn_i = 1'b1;
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge PCLK_i);
            if (rsp_valid_o != '0 || req_ready_o != '0 || eng_cmd_start_o || !sched_idle_o) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL midrst_late_done: got %0d activity cycles expected 0", extra); end
    endtask

    task automatic test_random();
        logic [37:0] g;
        for (int t = 0; t < 24; t++) begin
            int r;
            logic acmd;
            logic [5:0] ix;
            logic [31:0] a;
            r = $urandom_range(0, NR - 1);
            acmd = 1'($urandom_range(0, 1));
            ix = 6'($urandom_range(0, 63));
            if (ix == 6'd55) ix = 6'd56;
            a = $urandom;
            rca_i = 16'($urandom);
            eng_app_mode = $urandom_range(0, 2);
            eng_cmd_mode = $urandom_range(0, 2);
            eng_delay = $urandom_range(1, 6);
            eng_tail = $urandom_range(0, 3);
            eng_app_resp = {8'($urandom), $urandom};
            eng_app_resp[5] = 1'($urandom_range(0, 3) != 0);
            eng_resp = {8'($urandom), $urandom};
            model_txn(acmd, ix, a);
            run_txn(r, acmd, ix, a, 600);
            n_checks++;
            if (st_q.size() !== exp_st.size()) begin
                n_fail++; $display("FAIL rand%0d_starts: got %0d expected %0d", t, st_q.size(), exp_st.size());
            end
            for (int i = 0; i < exp_st.size(); i++) begin
                g = (i < st_q.size()) ? st_q[i] : 'x;
                n_checks++;
                if (g !== exp_st[i]) begin n_fail++; $display("FAIL rand%0d_cmd[%0d]: got %h expected %h", t, i, g, exp_st[i]); end
            end
            n_checks++;
            if ({got_rsp, rdy_cnt, rsp_vec, rsp_stat} !== {1'b1, 32'd1, NR'(1 << r), exp_status}) begin
                n_fail++; $display("FAIL rand%0d_resp: got %b/%0d/%b/%b expected 1/1/%b/%b", t, got_rsp, rdy_cnt, rsp_vec, rsp_stat, NR'(1 << r), exp_status);
            end
            if (exp_status == 2'b00 || exp_status == 2'b11) begin
                n_checks++;
                if (rsp_dat !== exp_data) begin n_fail++; $display("FAIL rand%0d_data: got %h expected %h", t, rsp_dat, exp_data); end
            end
        end
        n_checks++;
        if (busy_viol !== 0) begin n_fail++; $display("FAIL start_while_busy: got %0d expected 0", busy_viol); end
        eng_tail = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_acmd();
        test_retry();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
